// File: rtl/ama_riscv_mem_arb_pkg.sv
// Shared types and default widths for the IF/D memory arbiter.
// Optional perf counters are enabled with AMA_RISCV_MEM_ARB_PERF_EN.
package ama_riscv_mem_arb_pkg;

    localparam int unsigned ARB_AW           = 32;
    localparam int unsigned ARB_DW           = 32;
    localparam int unsigned ARB_MAX_D_STREAK = 4;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } arb_owner_t;

    // D wins by default; IF only wins when it is alone or D has used up its streak
    function automatic arb_owner_t arb_pick(input logic if_req,
                                            input logic d_req,
                                            input logic streak_full);
        if (if_req && (!d_req || streak_full)) return OWN_IF;
        return OWN_D;
    endfunction

endpackage

// File: rtl/ama_riscv_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at MAX_VAL.
module ama_riscv_sat_cnt #(
    parameter int unsigned     WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_VAL)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ama_riscv_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// Define AMA_RISCV_MEM_ARB_PERF_EN to add the perf_if_wait/perf_d_wait stall counters.
module ama_riscv_mem_arbiter
    import ama_riscv_mem_arb_pkg::*;
#(
    parameter int unsigned AW           = ARB_AW,
    parameter int unsigned DW           = ARB_DW,
    parameter int unsigned MAX_D_STREAK = ARB_MAX_D_STREAK
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rsp_valid,
    output logic [DW-1:0]   if_rsp_data,
    input  logic            d_req,
    input  logic [DW/8-1:0] d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rsp_valid,
    output logic [DW-1:0]   d_rsp_data,
    output logic            bus_req,
    output logic [AW-1:0]   bus_addr,
    output logic [DW/8-1:0] bus_we,
    output logic [DW-1:0]   bus_wdata,
    input  logic            bus_ready,
    input  logic            bus_rsp_valid,
    input  logic [DW-1:0]   bus_rsp_data
`ifdef AMA_RISCV_MEM_ARB_PERF_EN
    ,
    output logic [31:0]     perf_if_wait,
    output logic [31:0]     perf_d_wait
`endif
);

    localparam int unsigned   SW         = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_t    state_q, state_d;
    arb_owner_t    owner_q, owner_d;
    arb_owner_t    owner;
    logic          req;
    logic          issue;
    logic          rsp_hit;
    logic          own_d;
    logic [SW-1:0] streak;
    logic          streak_full;
    logic          streak_inc;
    logic          streak_clr;

    assign streak_full = (streak == STREAK_MAX);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        owner   = owner_q;
        req     = 1'b0;
        unique case (state_q)
            IDLE: begin
                owner = arb_pick(if_req, d_req, streak_full);
                req   = if_req | d_req;
                if (req) begin
                    owner_d = owner;
                    state_d = bus_ready ? WAIT : HOLD;
                end
            end
            HOLD: begin
                // Latched owner completes even if its requester has dropped req
                req = 1'b1;
                if (bus_ready) state_d = WAIT;
            end
            WAIT: begin
                if (bus_rsp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) req = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    assign issue  = req && bus_ready;
    assign own_d  = (owner == OWN_D);
    assign if_gnt = issue && !own_d;
    assign d_gnt  = issue && own_d;

    assign bus_req   = req;
    assign bus_addr  = !req ? '0 : (own_d ? d_addr : if_addr);
    assign bus_we    = (req && own_d) ? d_we : '0;
    assign bus_wdata = (req && own_d) ? d_wdata : '0;

    // Responses outside WAIT are protocol errors and are dropped
    assign rsp_hit      = !rst && (state_q == WAIT) && bus_rsp_valid;
    assign if_rsp_valid = rsp_hit && (owner_q == OWN_IF);
    assign d_rsp_valid  = rsp_hit && (owner_q == OWN_D);
    assign if_rsp_data  = if_rsp_valid ? bus_rsp_data : '0;
    assign d_rsp_data   = d_rsp_valid ? bus_rsp_data : '0;

    assign streak_inc = d_gnt && if_req;
    assign streak_clr = if_gnt || ((state_q == IDLE) && !if_req);

    ama_riscv_sat_cnt #(
        .WIDTH   (SW),
        .MAX_VAL (STREAK_MAX)
    ) u_streak (
        .clk   (clk),
        .rst   (rst),
        .clr_i (streak_clr),
        .inc_i (streak_inc),
        .cnt_o (streak)
    );

`ifdef AMA_RISCV_MEM_ARB_PERF_EN
    ama_riscv_sat_cnt #(
        .WIDTH (32)
    ) u_perf_if (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (if_req && !if_gnt),
        .cnt_o (perf_if_wait)
    );

    ama_riscv_sat_cnt #(
        .WIDTH (32)
    ) u_perf_d (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (d_req && !d_gnt),
        .cnt_o (perf_d_wait)
    );
`endif

endmodule
